// File: rtl/uart_sram_loader.sv
// UART byte stream to 16-bit SRAM word loader; ends the load on an idle time-out.
// Optional running checksum of written words when UART_LOADER_CHECKSUM_EN is defined.
module uart_sram_loader #(
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
   parameter logic [17:0] START_ADDRESS  = 18'd0
) (
   input  logic        Clock_50,
   input  logic        Reset,
   input  logic        Start,
   input  logic [7:0]  UART_rx_byte,
   input  logic        UART_rx_valid,
   output logic [17:0] SRAM_address,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n,
   output logic        Busy,
   output logic        Done,
   output logic        Overflow,
   output logic [18:0] Word_count,
   output logic [15:0] Checksum
);

   localparam int          TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [17:0] LAST_ADDR  = 18'h3FFFF;

   typedef enum logic [2:0] {S_IDLE, S_HIGH, S_LOW, S_FLUSH, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [17:0]   addr_q, addr_d;
   logic [15:0]   data_q, data_d;
   logic          we_n_q, we_n_d;
   logic [18:0]   count_q, count_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          first_seen_q, first_seen_d;
   logic          last_q, last_d;
   logic          overflow_q, overflow_d;

   logic retire, start_accept, timeout, end_reached;

   assign retire       = ~we_n_q;
   assign start_accept = Start && (state_q == S_IDLE || state_q == S_DONE);
   assign timeout      = first_seen_q && (timer_q == TIMER_LAST) && !UART_rx_valid;
   // The top address is used up once its write is in flight or has retired.
   assign end_reached  = last_q || (retire && addr_q == LAST_ADDR);

   // NOTE: every _d gets its default before the case so no path infers a latch.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      data_d       = data_q;
      we_n_d       = 1'b1;
      count_d      = count_q;
      timer_d      = timer_q;
      first_seen_d = first_seen_q;
      last_d       = last_q;
      overflow_d   = overflow_q;

      if (retire) begin
         count_d = count_q + 19'd1;
         if (addr_q == LAST_ADDR) last_d = 1'b1;
         else                     addr_d = addr_q + 18'd1;
      end

      if ((state_q == S_HIGH || state_q == S_LOW) && first_seen_q)
         timer_d = timer_q + TW'(1);

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_accept) begin
               state_d      = S_HIGH;
               addr_d       = START_ADDRESS;
               count_d      = '0;
               timer_d      = '0;
               first_seen_d = 1'b0;
               last_d       = 1'b0;
               overflow_d   = 1'b0;
            end
         end
         S_HIGH: begin
            if (UART_rx_valid) begin
               if (end_reached) begin
                  overflow_d = 1'b1;
                  state_d    = S_DONE;
               end else begin
                  data_d[15:8] = UART_rx_byte;
                  first_seen_d = 1'b1;
                  timer_d      = '0;
                  state_d      = S_LOW;
               end
            end else if (timeout) begin
               state_d = S_DONE;
            end
         end
         S_LOW: begin
            if (UART_rx_valid) begin
               data_d[7:0] = UART_rx_byte;
               we_n_d      = 1'b0;
               timer_d     = '0;
               state_d     = S_HIGH;
            end else if (timeout) begin
               data_d[7:0] = 8'h00;
               state_d     = S_FLUSH;
            end
         end
         S_FLUSH: begin
            // First cycle issues the padded word; the next sees it retire.
            if (retire) state_d = S_DONE;
            else        we_n_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clock_50 or posedge Reset) begin
      if (Reset) begin
         state_q      <= S_IDLE;
         addr_q       <= START_ADDRESS;
         data_q       <= '0;
         we_n_q       <= 1'b1;
         count_q      <= '0;
         timer_q      <= '0;
         first_seen_q <= 1'b0;
         last_q       <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         we_n_q       <= we_n_d;
         count_q      <= count_d;
         timer_q      <= timer_d;
         first_seen_q <= first_seen_d;
         last_q       <= last_d;
         overflow_q   <= overflow_d;
      end
   end

`ifdef UART_LOADER_CHECKSUM_EN
   logic [15:0] checksum_q;

   always_ff @(posedge Clock_50 or posedge Reset) begin
      if (Reset)             checksum_q <= '0;
      else if (start_accept) checksum_q <= '0;
      else if (retire)       checksum_q <= checksum_q + data_q;
   end

   assign Checksum = checksum_q;
`else
   assign Checksum = 16'h0000;
`endif

   assign SRAM_address    = addr_q;
   assign SRAM_write_data = data_q;
   assign SRAM_we_n       = we_n_q;
   assign Busy            = (state_q == S_HIGH) || (state_q == S_LOW) || (state_q == S_FLUSH);
   assign Done            = (state_q == S_DONE);
   assign Overflow        = overflow_q;
   assign Word_count      = count_q;

endmodule

// File: tb/tb_uart_sram_loader.sv
// Scoreboard bench for uart_sram_loader: a byte-level model queues expected SRAM
// writes, a negedge monitor pops and compares them; two instances cover start addresses 0 and 3FFFF.
`timescale 1ns/1ps
module tb_uart_sram_loader;

   localparam int T = 100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start_s [2];
   logic [7:0]  byte_s  [2];
   logic        valid_s [2];
   logic [17:0] addr_s  [2];
   logic [15:0] wdata_s [2];
   logic        we_n_s  [2];
   logic        busy_s  [2];
   logic        done_s  [2];
   logic        ovf_s   [2];
   logic [18:0] cnt_s   [2];
   logic [15:0] csum_s  [2];

   uart_sram_loader #(.TIMEOUT_CYCLES(T), .START_ADDRESS(18'd0)) dut (
      .Clock_50(clk), .Reset(rst), .Start(start_s[0]),
      .UART_rx_byte(byte_s[0]), .UART_rx_valid(valid_s[0]),
      .SRAM_address(addr_s[0]), .SRAM_write_data(wdata_s[0]), .SRAM_we_n(we_n_s[0]),
      .Busy(busy_s[0]), .Done(done_s[0]), .Overflow(ovf_s[0]),
      .Word_count(cnt_s[0]), .Checksum(csum_s[0]));

   uart_sram_loader #(.TIMEOUT_CYCLES(T), .START_ADDRESS(18'h3FFFF)) dut_top (
      .Clock_50(clk), .Reset(rst), .Start(start_s[1]),
      .UART_rx_byte(byte_s[1]), .UART_rx_valid(valid_s[1]),
      .SRAM_address(addr_s[1]), .SRAM_write_data(wdata_s[1]), .SRAM_we_n(we_n_s[1]),
      .Busy(busy_s[1]), .Done(done_s[1]), .Overflow(ovf_s[1]),
      .Word_count(cnt_s[1]), .Checksum(csum_s[1]));

   typedef struct packed {
      logic [0:0]  inst;
      logic [17:0] addr;
      logic [15:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  n_vec = 0;
   int  n_err = 0;
   int  cyc   = 0;
   int  done_rise [2];
   logic prev_low  [2];
   logic prev_done [2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every cycle with SRAM_we_n low must match the next queued write.
   always @(negedge clk) begin
      wr_t e;
      for (int k = 0; k < 2; k++) begin
         if (we_n_s[k] === 1'b0) begin
            check("we_n_pulse_width", {31'd0, prev_low[k]}, 32'd0);
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_write: inst %0d addr %0h data %0h, expected none", k, addr_s[k], wdata_s[k]);
            end else begin
               e = exp_q.pop_front();
               check("write_inst", k, {31'd0, e.inst});
               check("write_addr", {14'd0, addr_s[k]}, {14'd0, e.addr});
               check("write_data", {16'd0, wdata_s[k]}, {16'd0, e.data});
            end
         end
         prev_low[k] = (we_n_s[k] === 1'b0);
         if (done_s[k] === 1'b1 && prev_done[k] !== 1'b1) done_rise[k] = cyc;
         prev_done[k] = done_s[k];
      end
   end

   // Reference model of one load: byte list -> word list, plain arithmetic.
   bit          have_hi, full, ended, ovf;
   logic [7:0]  pend_hi;
   logic [17:0] next_addr;
   int          words, end_p;
   logic [15:0] sum;

   task automatic push_word(input int k, input logic [15:0] w);
      exp_q.push_back({k[0], next_addr, w});
      words++;
      sum = sum + w;
      if (next_addr == 18'h3FFFF) full = 1'b1;
      else                        next_addr = next_addr + 18'd1;
   endtask

   task automatic begin_load(input int k, input logic [17:0] base);
      have_hi = 0; full = 0; ended = 0; ovf = 0;
      next_addr = base; words = 0; sum = '0; end_p = 0;
      start_s[k] = 1'b1;
      @(negedge clk);
      start_s[k] = 1'b0;
   endtask

   task automatic send(input int k, input logic [7:0] b, input int gap);
      bit accepted;
      accepted = !ended;
      if (!ended) begin
         if (!have_hi) begin
            if (full) begin ovf = 1; ended = 1; end
            else begin pend_hi = b; have_hi = 1; end
         end else begin
            push_word(k, {pend_hi, b});
            have_hi = 0;
         end
      end
      byte_s[k] = b; valid_s[k] = 1'b1;
      @(negedge clk);
      valid_s[k] = 1'b0;
      if (accepted) end_p = cyc;
      repeat (gap) @(negedge clk);
   endtask

   task automatic finish_load(input int k);
      int delay_exp, waited;
      logic [15:0] csum_exp;
      if (ended)             delay_exp = 0;
      else if (have_hi) begin
         push_word(k, {pend_hi, 8'h00});
         have_hi = 0;
         delay_exp = T + 2;
      end else               delay_exp = T;
      waited = 0;
      while (done_s[k] !== 1'b1 && waited < 4 * T) begin
         @(negedge clk);
         waited++;
      end
      @(negedge clk);
      check("done", {31'd0, done_s[k]}, 32'd1);
      check("done_latency", done_rise[k] - end_p, delay_exp);
      check("busy_after_done", {31'd0, busy_s[k]}, 32'd0);
      check("word_count", {13'd0, cnt_s[k]}, words);
      check("overflow", {31'd0, ovf_s[k]}, {31'd0, ovf});
`ifdef UART_LOADER_CHECKSUM_EN
      csum_exp = sum;
`else
      csum_exp = 16'h0000;
`endif
      check("checksum", {16'd0, csum_s[k]}, {16'd0, csum_exp});
      check("writes_outstanding", exp_q.size(), 0);
   endtask

   task automatic check_reset_state(input int k, input logic [17:0] base);
      check("rst_addr", {14'd0, addr_s[k]}, {14'd0, base});
      check("rst_data", {16'd0, wdata_s[k]}, 32'd0);
      check("rst_we_n", {31'd0, we_n_s[k]}, 32'd1);
      check("rst_busy", {31'd0, busy_s[k]}, 32'd0);
      check("rst_done", {31'd0, done_s[k]}, 32'd0);
      check("rst_overflow", {31'd0, ovf_s[k]}, 32'd0);
      check("rst_word_count", {13'd0, cnt_s[k]}, 32'd0);
      check("rst_checksum", {16'd0, csum_s[k]}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         start_s[k] = 0; byte_s[k] = '0; valid_s[k] = 0;
         prev_low[k] = 0; prev_done[k] = 0; done_rise[k] = 0;
      end
      repeat (3) @(negedge clk);
      check_reset_state(0, 18'd0);
      check_reset_state(1, 18'h3FFFF);
      rst = 1'b0;
      @(negedge clk);

      // Even load with idle gaps
      begin_load(0, 18'd0);
      send(0, 8'h12, 5); send(0, 8'h34, 5); send(0, 8'hAB, 5); send(0, 8'hCD, 0);
      finish_load(0);

      // Odd load, padded flush word
      begin_load(0, 18'd0);
      send(0, 8'hFF, 3); send(0, 8'h01, 3); send(0, 8'h80, 0);
      finish_load(0);

      // Armed but silent: waits forever; Start while busy is ignored
      begin_load(0, 18'd0);
      repeat (1000) @(negedge clk);
      check("idle_busy", {31'd0, busy_s[0]}, 32'd1);
      check("idle_done", {31'd0, done_s[0]}, 32'd0);
      check("idle_count", {13'd0, cnt_s[0]}, 32'd0);
      send(0, 8'h5A, 2); send(0, 8'hC3, 2);
      start_s[0] = 1'b1; @(negedge clk); start_s[0] = 1'b0;
      send(0, 8'h77, 1); send(0, 8'h88, 0);
      finish_load(0);

      // Back-to-back bytes
      begin_load(0, 18'd0);
      for (int i = 0; i < 16; i++) send(0, 8'($urandom), 0);
      finish_load(0);

      // Randomized loads
      for (int l = 0; l < 6; l++) begin
         int n;
         n = $urandom_range(1, 20);
         begin_load(0, 18'd0);
         for (int i = 0; i < n; i++) send(0, 8'($urandom), (i == n - 1) ? 0 : $urandom_range(0, 3));
         finish_load(0);
      end

      // Top of address space: one write, then overflow
      begin_load(1, 18'h3FFFF);
      for (int i = 0; i < 4; i++) send(1, 8'($urandom), 0);
      finish_load(1);
      begin_load(1, 18'h3FFFF);
      send(1, 8'h42, 1); send(1, 8'h24, 0);
      finish_load(1);

      // Reset right after a low byte is accepted: write must never appear
      begin_load(0, 18'd0);
      send(0, 8'hDE, 2);
      have_hi = 0;
      byte_s[0] = 8'hAD; valid_s[0] = 1'b1;
      @(posedge clk);
      #1 rst = 1'b1;
      valid_s[0] = 1'b0;
      @(negedge clk);
      check_reset_state(0, 18'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post_reset_we_n", {31'd0, we_n_s[0]}, 32'd1);
      check("post_reset_busy", {31'd0, busy_s[0]}, 32'd0);
      check("post_reset_writes", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
